// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 at a 100 MHz clock) and the
// monitor's lock-FSM state encoding.
package vga_timing_pkg;

    localparam int H_PERIOD_640 = 3200;
    localparam int HS_WIDTH_640 = 384;
    localparam int V_LINES_640  = 525;
    localparam int VS_LINES_640 = 2;

    localparam logic [11:0] CNT_MAX  = 12'hFFF;
    localparam logic [9:0]  LINE_MAX = 10'h3FF;
    localparam logic [7:0]  ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_t;

    function automatic logic within_tol(input logic [11:0] meas, input int exp_v, input int tol);
        int d;
        d = int'(meas) - exp_v;
        return (d <= tol) && (d >= -tol);
    endfunction

endpackage

// File: rtl/vga_timing_monitor_sync_edge_detect.sv
// Two-flop synchronizer for an active-low sync line, followed by a
// registered edge detector; o_level is aligned with the edge pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_fall,
    output logic o_rise
);

    logic r_meta, r_sync, r_prev, r_fall, r_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fall <= r_prev & ~r_sync;
            r_rise <= ~r_prev & r_sync;
        end
    end

    assign o_level = r_prev;
    assign o_fall  = r_fall;
    assign o_rise  = r_rise;

endmodule

// File: rtl/vga_timing_monitor.sv
// Measures incoming hSync/vSync timing, compares it with the expected mode
// and reports lock status plus a saturating error count.
module vga_timing_monitor
    import vga_timing_pkg::*;
#(
    parameter int H_PERIOD_EXP = H_PERIOD_640,
    parameter int HS_WIDTH_EXP = HS_WIDTH_640,
    parameter int V_LINES_EXP  = V_LINES_640,
    parameter int VS_LINES_EXP = VS_LINES_640,
    parameter int TOL          = 4,
    parameter int LOCK_FRAMES  = 2,
    parameter int TIMEOUT      = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hSync,
    input  logic        vSync,
    output logic [11:0] line_period,
    output logic [11:0] hs_width,
    output logic [9:0]  frame_lines,
    output logic [9:0]  vs_lines,
    output logic        locked,
    output logic        frame_strobe,
    output logic [7:0]  err_count
);

    logic w_h_lvl, w_h_fall, w_h_rise;
    logic w_v_lvl, w_v_fall, w_v_rise;

    sync_edge_detect u_hs (.clk(clk), .rst_n(rst_n), .i_async(hSync),
                           .o_level(w_h_lvl), .o_fall(w_h_fall), .o_rise(w_h_rise));
    sync_edge_detect u_vs (.clk(clk), .rst_n(rst_n), .i_async(vSync),
                           .o_level(w_v_lvl), .o_fall(w_v_fall), .o_rise(w_v_rise));

    logic [11:0] r_cyc, r_wcnt, r_line_period, r_hs_width;
    logic [9:0]  r_lcnt, r_vscnt, r_frame_lines, r_vs_lines;
    logic [7:0]  r_err, r_good;
    logic        r_to_armed, r_locked;
    mon_state_t  r_state;

    logic        w_timeout, w_good;
    logic [11:0] w_lp_nxt, w_hw_nxt;
    logic [9:0]  w_lcnt_inc;
    logic [7:0]  w_err_inc;

    // The cycle counter parks at its maximum, so the arm flag keeps a long
    // hSync absence from being reported more than once.
    assign w_timeout  = r_to_armed && (r_cyc == 12'(TIMEOUT)) && !w_h_fall;
    assign w_lp_nxt   = w_h_fall ? r_cyc : r_line_period;
    assign w_hw_nxt   = w_h_rise ? r_wcnt : r_hs_width;
    assign w_lcnt_inc = (w_h_fall && r_lcnt != LINE_MAX) ? r_lcnt + 10'd1 : r_lcnt;
    assign w_err_inc  = (r_err == ERR_MAX) ? r_err : r_err + 8'd1;

    // Judged on the values as they stand after this cycle's updates, so a
    // coincident hSync fall is part of the frame that is closing.
    assign w_good = within_tol(w_lp_nxt, H_PERIOD_EXP, TOL) &&
                    within_tol(w_hw_nxt, HS_WIDTH_EXP, TOL) &&
                    (w_lcnt_inc == 10'(V_LINES_EXP)) &&
                    (r_vs_lines == 10'(VS_LINES_EXP));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc         <= '0;
            r_wcnt        <= '0;
            r_lcnt        <= '0;
            r_vscnt       <= '0;
            r_line_period <= '0;
            r_hs_width    <= '0;
            r_frame_lines <= '0;
            r_vs_lines    <= '0;
            r_to_armed    <= 1'b1;
        end else begin
            if (w_h_fall) begin
                r_cyc         <= 12'd1;
                r_line_period <= r_cyc;
                r_to_armed    <= 1'b1;
            end else begin
                if (r_cyc != CNT_MAX) r_cyc <= r_cyc + 12'd1;
                if (w_timeout)        r_to_armed <= 1'b0;
            end

            if (w_h_fall)                            r_wcnt <= 12'd1;
            else if (!w_h_lvl && r_wcnt != CNT_MAX) r_wcnt <= r_wcnt + 12'd1;
            if (w_h_rise) r_hs_width <= r_wcnt;

            if (w_v_fall) begin
                r_frame_lines <= w_lcnt_inc;
                r_lcnt        <= '0;
            end else begin
                r_lcnt <= w_lcnt_inc;
            end

            if (w_v_fall)
                r_vscnt <= {9'd0, w_h_fall};
            else if (!w_v_lvl && w_h_fall && r_vscnt != LINE_MAX)
                r_vscnt <= r_vscnt + 10'd1;
            if (w_v_rise) r_vs_lines <= r_vscnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_SEARCH;
            r_good   <= '0;
            r_locked <= 1'b0;
            r_err    <= '0;
        end else if (w_timeout) begin
            r_state  <= ST_SEARCH;
            r_good   <= '0;
            r_locked <= 1'b0;
            r_err    <= w_err_inc;
        end else if (w_v_fall) begin
            case (r_state)
                ST_SEARCH: begin
                    r_state <= ST_CHECK;
                    r_good  <= '0;
                end
                ST_CHECK: begin
                    if (!w_good) begin
                        r_good <= '0;
                        r_err  <= w_err_inc;
                    end else if (int'(r_good) + 1 >= LOCK_FRAMES) begin
                        r_state  <= ST_LOCKED;
                        r_locked <= 1'b1;
                        r_good   <= '0;
                    end else begin
                        r_good <= r_good + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (!w_good) begin
                        r_state  <= ST_SEARCH;
                        r_locked <= 1'b0;
                        r_err    <= w_err_inc;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign line_period  = r_line_period;
    assign hs_width     = r_hs_width;
    assign frame_lines  = r_frame_lines;
    assign vs_lines     = r_vs_lines;
    assign locked       = r_locked;
    assign frame_strobe = w_v_fall;
    assign err_count    = r_err;

endmodule
